// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect scheduler for the 5-stage pipeline, fixed-priority hazard resolution.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             ex_busy,
    input  logic             mem_wait,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             except_valid,
    input  logic [31:0]      except_entry,
    input  logic             ertn_valid,
    input  logic [31:0]      era,
    input  logic             idle_valid,
    input  logic             int_pending,
    output logic [4:0]       stall,
    output logic [4:0]       flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    typedef enum logic [1:0] {RUN, FLUSH, IDLE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [4:0]  stall_c, flush_c;
    logic        redir_c;
    logic [31:0] redir_pc_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        stall_c    = 5'b00000;
        flush_c    = 5'b00000;
        redir_c    = 1'b0;
        redir_pc_c = 32'h0;
        state_nxt  = state;
        cnt_nxt    = cnt;
        if (except_valid || ertn_valid) begin
            // except wins over a simultaneous ertn
            flush_c    = 5'b11110;
            redir_c    = 1'b1;
            redir_pc_c = except_valid ? except_entry : era;
            state_nxt  = FLUSH;
            cnt_nxt    = FLUSH_CYCLES[3:0];
        end else begin
            case (state)
                FLUSH: begin
                    flush_c = 5'b00010;
                    if (cnt <= 4'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = 4'd0;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                IDLE: begin
                    stall_c = 5'b00001;
                    flush_c = 5'b00010;
                    if (int_pending) state_nxt = RUN;
                end
                default: begin
                    if (mem_wait) begin
                        stall_c = 5'b01111;
                        flush_c = 5'b10000;
                    end else begin
                        // a branch blocked by ex_busy stays in EX and is retried later
                        if (ex_busy) begin
                            stall_c = 5'b00111;
                            flush_c = 5'b01000;
                        end else if (br_taken) begin
                            flush_c    = 5'b00110;
                            redir_c    = 1'b1;
                            redir_pc_c = br_target;
                        end else if (load_use) begin
                            stall_c = 5'b00011;
                            flush_c = 5'b00100;
                        end
                        if (idle_valid) state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    assign stall          = rst_n ? stall_c    : 5'b00000;
    assign flush          = rst_n ? flush_c    : 5'b11111;
    assign redirect_valid = rst_n ? redir_c    : 1'b0;
    assign redirect_pc    = rst_n ? redir_pc_c : 32'h0;

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall[0])       perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: RUN-state vector table plus exception, IDLE and reset sequences.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_use, ex_busy, mem_wait, br_taken;
    logic [31:0] br_target;
    logic        except_valid, ertn_valid, idle_valid, int_pending;
    logic [31:0] except_entry, era;
    logic [4:0]  stall, flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_use(load_use), .ex_busy(ex_busy), .mem_wait(mem_wait),
        .br_taken(br_taken), .br_target(br_target),
        .except_valid(except_valid), .except_entry(except_entry),
        .ertn_valid(ertn_valid), .era(era),
        .idle_valid(idle_valid), .int_pending(int_pending),
        .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    typedef struct {
        logic        lu, eb, mw, bt;
        logic [31:0] tgt;
        logic [4:0]  st, fl;
        logic        rv;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [4:0] st, input logic [4:0] fl,
                             input logic rv, input logic [31:0] pc);
        check({name, ".stall"}, {27'd0, stall}, {27'd0, st});
        check({name, ".flush"}, {27'd0, flush}, {27'd0, fl});
        check({name, ".rv"}, {31'd0, redirect_valid}, {31'd0, rv});
        check({name, ".pc"}, redirect_pc, pc);
    endtask

    task automatic clear_inputs();
        load_use = 0; ex_busy = 0; mem_wait = 0; br_taken = 0; br_target = 32'h0;
        except_valid = 0; ertn_valid = 0; idle_valid = 0; int_pending = 0;
        except_entry = 32'h0; era = 32'h0;
    endtask

    logic [31:0] snap;
    logic [31:0] exp_delta;

    initial begin
        //            lu eb mw bt target        stall     flush     rv pc
        vecs[0] = '{0, 0, 0, 0, 32'h0,        5'b00000, 5'b00000, 0, 32'h0};
        vecs[1] = '{1, 0, 0, 0, 32'h0,        5'b00011, 5'b00100, 0, 32'h0};
        vecs[2] = '{0, 0, 0, 0, 32'h0,        5'b00000, 5'b00000, 0, 32'h0};
        vecs[3] = '{0, 0, 0, 1, 32'h1c000100, 5'b00000, 5'b00110, 1, 32'h1c000100};
        vecs[4] = '{0, 1, 0, 1, 32'h1c000100, 5'b00111, 5'b01000, 0, 32'h0};
        vecs[5] = '{0, 0, 1, 1, 32'h1c000100, 5'b01111, 5'b10000, 0, 32'h0};
        vecs[6] = '{0, 1, 1, 0, 32'h0,        5'b01111, 5'b10000, 0, 32'h0};
        vecs[7] = '{1, 1, 0, 0, 32'h0,        5'b00111, 5'b01000, 0, 32'h0};
        vecs[8] = '{1, 0, 0, 1, 32'h00000004, 5'b00000, 5'b00110, 1, 32'h00000004};
        vecs[9] = '{0, 1, 0, 0, 32'h0,        5'b00111, 5'b01000, 0, 32'h0};

        clear_inputs();
        rst_n = 1'b0;
        #1;
        check_out("reset", 5'b00000, 5'b11111, 1'b0, 32'h0);
        check("reset.perf_stall", perf_stall_cnt, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check_out("post_reset", 5'b00000, 5'b00000, 1'b0, 32'h0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            load_use = vecs[i].lu; ex_busy = vecs[i].eb; mem_wait = vecs[i].mw;
            br_taken = vecs[i].bt; br_target = vecs[i].tgt;
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].fl, vecs[i].rv, vecs[i].pc);
        end

        // exception during mem_wait, then two FLUSH cycles that outrank mem_wait/br_taken
        @(negedge clk);
        clear_inputs();
        snap = perf_flush_cnt;
        except_valid = 1; except_entry = 32'h1c008000; mem_wait = 1;
        #1;
        check_out("exc", 5'b00000, 5'b11110, 1'b1, 32'h1c008000);
        @(negedge clk);
        except_valid = 0; br_taken = 1; br_target = 32'h1c000200;
        #1;
        check_out("flush1", 5'b00000, 5'b00010, 1'b0, 32'h0);
        @(negedge clk); #1;
        check_out("flush2", 5'b00000, 5'b00010, 1'b0, 32'h0);
        @(negedge clk); #1;
        check_out("exc_run", 5'b01111, 5'b10000, 1'b0, 32'h0);
`ifdef PIPE_PERF_CNT_EN
        exp_delta = 32'd1;
`else
        exp_delta = 32'd0;
`endif
        check("perf_flush_delta", perf_flush_cnt - snap, exp_delta);

        // except and ertn together, then ertn alone
        @(negedge clk);
        clear_inputs();
        except_valid = 1; ertn_valid = 1; except_entry = 32'h1c008000; era = 32'h1c000040;
        #1;
        check_out("exc_ertn", 5'b00000, 5'b11110, 1'b1, 32'h1c008000);
        @(negedge clk) clear_inputs();
        @(negedge clk);
        @(negedge clk);
        ertn_valid = 1; era = 32'h1c000040;
        #1;
        check_out("ertn", 5'b00000, 5'b11110, 1'b1, 32'h1c000040);
        @(negedge clk) clear_inputs();
        @(negedge clk);
        @(negedge clk); #1;
        check_out("ertn_run", 5'b00000, 5'b00000, 1'b0, 32'h0);

        // IDLE entry, wait and wake-up
        @(negedge clk);
        idle_valid = 1;
        #1;
        check_out("idle_enter", 5'b00000, 5'b00000, 1'b0, 32'h0);
        snap = perf_stall_cnt;
        @(negedge clk);
        idle_valid = 0;
        #1;
        check_out("idle1", 5'b00001, 5'b00010, 1'b0, 32'h0);
        @(negedge clk);
        br_taken = 1; br_target = 32'h1c000300;
        #1;
        check_out("idle_br", 5'b00001, 5'b00010, 1'b0, 32'h0);
        @(negedge clk);
        br_taken = 0; int_pending = 1;
        #1;
        check_out("idle_wake", 5'b00001, 5'b00010, 1'b0, 32'h0);
        @(negedge clk);
        int_pending = 0;
        #1;
        check_out("idle_run", 5'b00000, 5'b00000, 1'b0, 32'h0);
`ifdef PIPE_PERF_CNT_EN
        exp_delta = 32'd3;
`else
        exp_delta = 32'd0;
`endif
        check("perf_stall_delta", perf_stall_cnt - snap, exp_delta);

        // reset in the middle of IDLE returns to RUN
        @(negedge clk) idle_valid = 1;
        @(negedge clk) idle_valid = 0;
        #1;
        check_out("idle_again", 5'b00001, 5'b00010, 1'b0, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        check_out("idle_reset", 5'b00000, 5'b11111, 1'b0, 32'h0);
        check("idle_reset.perf_stall", perf_stall_cnt, 32'h0);
        check("idle_reset.perf_flush", perf_flush_cnt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; br_taken = 1; br_target = 32'h1c000400;
        #1;
        check_out("after_reset_br", 5'b00000, 5'b00110, 1'b1, 32'h1c000400);
        @(negedge clk) clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
